// File: rtl/cnn_out_packer_if.sv
// Handshake bundle for cnn_out_packer: 64-bit CNN word stream in, 512-bit beat stream out.
// m_keep exists only when CNN_OUT_PACKER_KEEP_EN is defined.
interface cnn_out_packer_if;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] m_data;
  logic         m_last;
`ifdef CNN_OUT_PACKER_KEEP_EN
  logic [7:0]   m_keep;
`endif

  // Environment side: sources CNN words, sinks packed beats
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
`ifdef CNN_OUT_PACKER_KEEP_EN
    , input m_keep
`endif
  );

  // Packer side: sinks CNN words, sources packed beats
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
`ifdef CNN_OUT_PACKER_KEEP_EN
    , output m_keep
`endif
  );
endinterface

// File: rtl/cnn_out_packer.sv
// cnn_out_packer: packs 64-bit CNN result words into 512-bit beats, eight lanes per beat,
// closing a short padded beat at the end of each image.
// Optional feature: define CNN_OUT_PACKER_KEEP_EN to add the m_keep lane-valid output.
module cnn_out_packer #(
  parameter int unsigned WORDS_PER_FRAME = 10,
  parameter logic [63:0] PAD_WORD        = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  cnn_out_packer_if.slave   bus,
  output logic [31:0]       frames_done
);

  localparam logic [15:0] LAST_IDX = 16'(WORDS_PER_FRAME - 1);

  typedef enum logic {ST_FILL, ST_PEND} state_t;

  state_t             state_q, state_d;
  logic [2:0]         lane_q, lane_d;
  logic [15:0]        wif_q, wif_d;
  logic [7:0][63:0]   acc_q, acc_d;
  logic               pend_last_q, pend_last_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic [511:0]       m_data_q, m_data_d;
  logic [31:0]        frames_done_q, frames_done_d;
`ifdef CNN_OUT_PACKER_KEEP_EN
  logic [7:0]         pend_keep_q, pend_keep_d;
  logic [7:0]         m_keep_q, m_keep_d;
  logic [7:0]         keep;
`endif

  logic               s_ready;
  logic               accept;
  logic               out_free;
  logic               frame_end;
  logic               complete;
  logic [7:0][63:0]   beat;

  assign s_ready       = !reset && (state_q == ST_FILL);
  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;
  assign frames_done   = frames_done_q;
`ifdef CNN_OUT_PACKER_KEEP_EN
  assign bus.m_keep    = m_keep_q;
`endif

  // Next-state: accumulate words, complete beats, hand them to the output register or park them
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    wif_d         = wif_q;
    acc_d         = acc_q;
    pend_last_d   = pend_last_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;
    frames_done_d = frames_done_q;
`ifdef CNN_OUT_PACKER_KEEP_EN
    pend_keep_d   = pend_keep_q;
    m_keep_d      = m_keep_q;
`endif

    out_free  = !m_valid_q || bus.m_ready;
    accept    = bus.s_valid && s_ready;
    frame_end = (wif_q == LAST_IDX);
    complete  = accept && (frame_end || (lane_q == 3'd7));

    // Beat as it would look if the current word closes it: earlier lanes from the accumulator,
    // this word in its lane, PAD_WORD above it
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < 32'(lane_q))       beat[3'(k)] = acc_q[3'(k)];
      else if (k == 32'(lane_q)) beat[3'(k)] = bus.s_data;
      else                       beat[3'(k)] = PAD_WORD;
`ifdef CNN_OUT_PACKER_KEEP_EN
      keep[3'(k)] = (k <= 32'(lane_q));
`endif
    end

    // Drain of the output register; a load below overrides it in the same cycle
    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
`ifdef CNN_OUT_PACKER_KEEP_EN
      m_keep_d  = '0;
`endif
      if (m_last_q) frames_done_d = frames_done_q + 32'd1;
    end

    if (accept) begin
      acc_d[lane_q] = bus.s_data;
      wif_d         = frame_end ? '0 : wif_q + 16'd1;
      lane_d        = complete ? '0 : lane_q + 3'd1;
      if (complete) begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = beat;
          m_last_d  = frame_end;
`ifdef CNN_OUT_PACKER_KEEP_EN
          m_keep_d  = keep;
`endif
        end else begin
          // Output register busy: park the finished (padded) beat in the accumulator
          acc_d       = beat;
          pend_last_d = frame_end;
          state_d     = ST_PEND;
`ifdef CNN_OUT_PACKER_KEEP_EN
          pend_keep_d = keep;
`endif
        end
      end
    end else if ((state_q == ST_PEND) && out_free) begin
      m_valid_d = 1'b1;
      m_data_d  = acc_q;
      m_last_d  = pend_last_q;
      state_d   = ST_FILL;
`ifdef CNN_OUT_PACKER_KEEP_EN
      m_keep_d  = pend_keep_q;
`endif
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FILL;
      lane_q        <= '0;
      wif_q         <= '0;
      acc_q         <= '0;
      pend_last_q   <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
      frames_done_q <= '0;
`ifdef CNN_OUT_PACKER_KEEP_EN
      pend_keep_q   <= '0;
      m_keep_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      wif_q         <= wif_d;
      acc_q         <= acc_d;
      pend_last_q   <= pend_last_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
      frames_done_q <= frames_done_d;
`ifdef CNN_OUT_PACKER_KEEP_EN
      pend_keep_q   <= pend_keep_d;
      m_keep_q      <= m_keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_cnn_out_packer.sv
// Testbench for cnn_out_packer: three instances (10, 16 and 1 words per frame).
module tb_cnn_out_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_out_packer_if if10();
  cnn_out_packer_if if16();
  cnn_out_packer_if if1();
  logic [31:0] fd10, fd16, fd1;

  cnn_out_packer #(.WORDS_PER_FRAME(10), .PAD_WORD(64'h0)) u10 (
    .clk(clk), .reset(reset), .bus(if10), .frames_done(fd10));
  cnn_out_packer #(.WORDS_PER_FRAME(16), .PAD_WORD(64'h0)) u16 (
    .clk(clk), .reset(reset), .bus(if16), .frames_done(fd16));
  cnn_out_packer #(.WORDS_PER_FRAME(1), .PAD_WORD(64'hDEAD)) u1 (
    .clk(clk), .reset(reset), .bus(if1), .frames_done(fd1));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [511:0] d;
    logic         last;
    logic [7:0]   keep;
  } beat_t;

  beat_t q10[$], q16[$], q1[$];
  beat_t b10, b16, b1;

  typedef struct {
    logic         sv;
    logic [63:0]  sd;
    logic         mr;
    logic         exp_srdy;
    logic         exp_mv;
    logic         exp_ml;
    logic         chk_d;
    logic [511:0] exp_d;
    logic [31:0]  exp_fd;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [63:0] W(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat monitors: a transfer is recorded mid-cycle, ahead of the edge that completes it
  always @(negedge clk) begin
    if (!reset && if10.m_valid && if10.m_ready) begin
      b10.d = if10.m_data; b10.last = if10.m_last;
`ifdef CNN_OUT_PACKER_KEEP_EN
      b10.keep = if10.m_keep;
`else
      b10.keep = '0;
`endif
      q10.push_back(b10);
    end
    if (!reset && if16.m_valid && if16.m_ready) begin
      b16.d = if16.m_data; b16.last = if16.m_last;
`ifdef CNN_OUT_PACKER_KEEP_EN
      b16.keep = if16.m_keep;
`else
      b16.keep = '0;
`endif
      q16.push_back(b16);
    end
    if (!reset && if1.m_valid && if1.m_ready) begin
      b1.d = if1.m_data; b1.last = if1.m_last;
`ifdef CNN_OUT_PACKER_KEEP_EN
      b1.keep = if1.m_keep;
`else
      b1.keep = '0;
`endif
      q1.push_back(b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] exp0, exp1;
    int accepted, cyc, lows;

    reset = 1'b1;
    if10.s_valid = 0; if10.s_data = '0; if10.m_ready = 0;
    if16.s_valid = 0; if16.s_data = '0; if16.m_ready = 0;
    if1.s_valid  = 0; if1.s_data  = '0; if1.m_ready  = 0;

    // Table for the 10-word frame: words 1..10 back-to-back, m_ready high
    for (int k = 0; k < 8; k++) exp0[64*k +: 64] = W(k + 1);
    exp1 = '0;
    exp1[63:0]   = W(9);
    exp1[127:64] = W(10);
    for (int i = 0; i < 12; i++) begin
      tbl[i].sv = (i < 10); tbl[i].sd = (i < 10) ? W(i + 1) : '0;
      tbl[i].mr = (i < 11); tbl[i].exp_srdy = 1'b1;
      tbl[i].exp_mv = 1'b0; tbl[i].exp_ml = 1'b0; tbl[i].chk_d = 1'b0;
      tbl[i].exp_d = '0; tbl[i].exp_fd = (i >= 10) ? 32'd1 : 32'd0;
    end
    tbl[7].exp_mv = 1'b1; tbl[7].chk_d = 1'b1; tbl[7].exp_d = exp0;
    tbl[9].exp_mv = 1'b1; tbl[9].exp_ml = 1'b1; tbl[9].chk_d = 1'b1; tbl[9].exp_d = exp1;

    // Reset state
    tick(); tick();
    chk("rst_m_valid", 512'(if10.m_valid), 512'(0));
    chk("rst_m_last", 512'(if10.m_last), 512'(0));
    chk("rst_m_data", if10.m_data, '0);
    chk("rst_frames_done", 512'(fd10), 512'(0));
    chk("rst_s_ready_low", 512'(if10.s_ready), 512'(0));
`ifdef CNN_OUT_PACKER_KEEP_EN
    chk("rst_m_keep", 512'(if10.m_keep), 512'(0));
`endif
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", 512'(if10.s_ready), 512'(1));

    // Table-driven: one frame of 10 words
    for (int i = 0; i < 12; i++) begin
      if10.s_valid = tbl[i].sv; if10.s_data = tbl[i].sd; if10.m_ready = tbl[i].mr;
      #1;
      chk($sformatf("A%0d_s_ready", i), 512'(if10.s_ready), 512'(tbl[i].exp_srdy));
      tick();
      chk($sformatf("A%0d_m_valid", i), 512'(if10.m_valid), 512'(tbl[i].exp_mv));
      chk($sformatf("A%0d_m_last", i), 512'(if10.m_last), 512'(tbl[i].exp_ml));
      chk($sformatf("A%0d_frames", i), 512'(fd10), 512'(tbl[i].exp_fd));
      if (tbl[i].chk_d) chk($sformatf("A%0d_m_data", i), if10.m_data, tbl[i].exp_d);
    end
    if10.m_ready = 0;

    // 16-word frames, 32 continuous words, m_ready high
    q16.delete();
    lows = 0;
    for (int i = 1; i <= 32; i++) begin
      if16.s_valid = 1; if16.s_data = W(1000 + i); if16.m_ready = 1;
      #1;
      if (!if16.s_ready) lows++;
      tick();
    end
    if16.s_valid = 0;
    tick(); tick(); tick();
    chk("B_s_ready_lows", 512'(lows), 512'(0));
    chk("B_beat_count", 512'(q16.size()), 512'(4));
    for (int b = 0; b < 4; b++) begin
      if (b < q16.size()) begin
        for (int k = 0; k < 8; k++) exp0[64*k +: 64] = W(1000 + 8*b + k + 1);
        chk($sformatf("B_beat%0d_data", b), q16[b].d, exp0);
        chk($sformatf("B_beat%0d_last", b), 512'(q16[b].last), 512'(b % 2));
      end
    end
    chk("B_frames", 512'(fd16), 512'(2));

    // Backpressure: m_ready low while 16 words are offered
    q16.delete();
    if16.m_ready = 0;
    accepted = 0; cyc = 0;
    while (accepted < 16 && cyc < 40) begin
      if16.s_valid = 1; if16.s_data = W(2000 + accepted + 1);
      #1;
      if (if16.s_ready) accepted++;
      tick();
      cyc++;
    end
    chk("C_accepted", 512'(accepted), 512'(16));
    for (int k = 0; k < 8; k++) exp0[64*k +: 64] = W(2000 + k + 1);
    for (int k = 0; k < 8; k++) exp1[64*k +: 64] = W(2000 + 8 + k + 1);
    if16.s_data = W(2017);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("C_stall%0d_s_ready", i), 512'(if16.s_ready), 512'(0));
      chk($sformatf("C_stall%0d_m_valid", i), 512'(if16.m_valid), 512'(1));
      chk($sformatf("C_stall%0d_m_data", i), if16.m_data, exp0);
      tick();
    end
    if16.s_valid = 0; if16.m_ready = 1;
    cyc = 0;
    while (q16.size() < 2 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick(); tick(); tick();
    chk("C_beat_count", 512'(q16.size()), 512'(2));
    if (q16.size() >= 2) begin
      chk("C_beat0_data", q16[0].d, exp0);
      chk("C_beat0_last", 512'(q16[0].last), 512'(0));
      chk("C_beat1_data", q16[1].d, exp1);
      chk("C_beat1_last", 512'(q16[1].last), 512'(1));
    end
    chk("C_s_ready_back", 512'(if16.s_ready), 512'(1));
    chk("C_frames", 512'(fd16), 512'(3));
    if16.m_ready = 0;

    // Reset pulsed after 5 of 10 words
    if10.m_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      if10.s_valid = 1; if10.s_data = W(3000 + i);
      tick();
    end
    if10.s_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("D_m_valid", 512'(if10.m_valid), 512'(0));
    chk("D_frames", 512'(fd10), 512'(0));
    q10.delete();
    for (int i = 1; i <= 10; i++) begin
      if10.s_valid = 1; if10.s_data = W(3100 + i);
      tick();
    end
    if10.s_valid = 0;
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) exp0[64*k +: 64] = W(3100 + k + 1);
    exp1 = '0;
    exp1[63:0]   = W(3109);
    exp1[127:64] = W(3110);
    chk("D_beat_count", 512'(q10.size()), 512'(2));
    if (q10.size() >= 2) begin
      chk("D_beat0_data", q10[0].d, exp0);
      chk("D_beat0_last", 512'(q10[0].last), 512'(0));
      chk("D_beat1_data", q10[1].d, exp1);
      chk("D_beat1_last", 512'(q10[1].last), 512'(1));
`ifdef CNN_OUT_PACKER_KEEP_EN
      chk("D_beat0_keep", 512'(q10[0].keep), 512'(8'hFF));
      chk("D_beat1_keep", 512'(q10[1].keep), 512'(8'h03));
`endif
    end
    chk("D_frames_after", 512'(fd10), 512'(1));

    // One word per frame with PAD_WORD 64'hDEAD
    q1.delete();
    for (int i = 1; i <= 3; i++) begin
      if1.s_valid = 1; if1.s_data = W(4000 + i); if1.m_ready = 1;
      tick();
    end
    if1.s_valid = 0;
    tick(); tick();
    chk("E_beat_count", 512'(q1.size()), 512'(3));
    for (int b = 0; b < 3; b++) begin
      if (b < q1.size()) begin
        exp0[63:0] = W(4000 + b + 1);
        for (int k = 1; k < 8; k++) exp0[64*k +: 64] = 64'hDEAD;
        chk($sformatf("E_beat%0d_data", b), q1[b].d, exp0);
        chk($sformatf("E_beat%0d_last", b), 512'(q1[b].last), 512'(1));
`ifdef CNN_OUT_PACKER_KEEP_EN
        chk($sformatf("E_beat%0d_keep", b), 512'(q1[b].keep), 512'(8'h01));
`endif
      end
    end
    chk("E_frames", 512'(fd1), 512'(3));

    // frames_done wrap from all-ones
    force u10.frames_done_q = 32'hFFFF_FFFF;
    tick();
    release u10.frames_done_q;
    tick();
    chk("F_preload", 512'(fd10), 512'(32'hFFFF_FFFF));
    for (int i = 1; i <= 10; i++) begin
      if10.s_valid = 1; if10.s_data = W(5000 + i);
      tick();
    end
    if10.s_valid = 0;
    tick(); tick(); tick();
    chk("F_wrap", 512'(fd10), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnn_out_packer.md
CNN_OUT_PACKER -- requirements
Module: cnn_out_packer

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 10: number of 64-bit CNN result words per image, legal range 1..65535.
REQ-002 SHALL have parameter PAD_WORD, default 64'h0: value written into unused lanes of a frame-final partial beat.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 1: CNN result word valid.
REQ-006 SHALL have port s_ready, output, 1: packer accepts word.
REQ-007 SHALL have port s_data, input, 64: CNN result word, {bits_3,bits_2,bits_1,bits_0}.
REQ-008 SHALL have port m_valid, output, 1: packed beat valid toward output FIFO.
REQ-009 SHALL have port m_ready, input, 1: downstream accepts beat.
REQ-010 SHALL have port m_data, output, 512: packed beat.
REQ-011 SHALL have port m_last, output, 1: beat is the final beat of an image.
REQ-012 SHALL have port frames_done, output, 32: count of images whose last beat has been accepted downstream.

Function
REQ-013 SHALL accept a word when s_valid && s_ready, and transfer a beat when m_valid && m_ready.
REQ-014 SHALL place word k of a beat (k = 0..7) in m_data[64k+63:64k], with the first-accepted word in lane 0.
REQ-015 SHALL complete a beat on the 8th word, or on the word that is word WORDS_PER_FRAME of the image, whichever comes first.
REQ-016 SHALL fill each unused lane of a frame-final partial beat with PAD_WORD.
REQ-017 SHALL assert m_last with the beat completed by word WORDS_PER_FRAME; m_last SHALL be 0 on every other beat.
REQ-018 SHALL use a two-stage datapath: an accumulator (lane counter 0..7) and an output register (m_valid/m_data/m_last).
REQ-019 SHALL load the completed beat directly into the output register, in the same cycle as the completing word, when the output register is empty or being drained (m_ready high) that cycle; m_valid SHALL rise the next cycle.
REQ-020 SHALL otherwise hold the completed beat in the accumulator with a pending flag set, and drive s_ready = 0 while pending.
REQ-021 SHALL, while pending, move the beat to the output register in the first cycle the output register is empty or drained, then clear pending and restore s_ready = 1 in the following cycle.
REQ-022 SHALL sustain one word per cycle with m_ready held high: no bubble on s_ready.
REQ-023 SHALL hold m_data, m_last and m_valid stable while m_valid && !m_ready.
REQ-024 SHALL use a 16-bit word-in-frame counter that returns to 0 after word WORDS_PER_FRAME; the next word starts a new image in lane 0.
REQ-025 SHALL increment frames_done by 1 on each accepted m_last beat, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL NOT let s_valid deasserting mid-beat or mid-frame flush a partial beat; only frame end or 8 words complete a beat.

Reset
REQ-027 SHALL, on reset high at a rising edge, clear the lane counter, word-in-frame counter, pending flag, m_valid, m_last and frames_done, and set m_data to 0.
REQ-028 SHALL discard any partial or pending beat on reset asserted mid-frame; the first word after reset SHALL be word 1 of a new image.
REQ-029 SHALL drive s_ready = 0 while reset is high, and s_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with CNN_OUT_PACKER_KEEP_EN defined, add output port m_keep[7:0]: bit k = 1 iff lane k holds a real word, 0 when m_valid = 0 and after reset, and 8'hFF on full beats.
REQ-031 SHALL, without CNN_OUT_PACKER_KEEP_EN, omit the m_keep port and logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover: WORDS_PER_FRAME=10, words 1..10 back-to-back, m_ready=1 -> beat0 = words 1..8, m_last=0; beat1 = lanes0-1 words 9,10, lanes2-7 = 0, m_last=1; frames_done=1.
REQ-033 SHALL cover: WORDS_PER_FRAME=16, 32 continuous words, m_ready=1 -> 4 beats; m_last on beats 1 and 3; s_ready never low; frames_done=2.
REQ-034 SHALL cover: m_ready=0 while 16 words are offered -> after 16 accepted words s_ready=0 and m_data holds beat0 unchanged; m_ready=1 -> beats drain in order, no loss or duplication.
REQ-035 SHALL cover: reset pulsed after 5 of 10 words -> m_valid=0 and frames_done=0; next 10 words form a clean frame with word 1 in lane 0.
REQ-036 SHALL cover: WORDS_PER_FRAME=1, PAD_WORD=64'hDEAD, KEEP_EN defined -> each word yields one beat with m_last=1, lanes1-7 = 64'hDEAD, m_keep = 8'h01.
REQ-037 SHALL cover: frames_done preloaded to 0xFFFFFFFF via force, then one frame -> frames_done = 0.
